maq_regressiva: RTL and testbench

MAQ_REGRESSIVA -- requirements
Module: maq_regressiva

---
 rtl/maq_regressiva_if.sv | 32 +++
 rtl/maq_regressiva.sv | 144 ++++++++++++++
 tb/tb_maq_regressiva.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/maq_regressiva_if.sv
// Handshake and digit bus of the countdown timer: controls and preset in, remaining time and flags out.
interface maq_regressiva_if;
   logic       maqs_enable;
   logic       maqs_load;
   logic       maqs_start;
   logic       maqs_stop;
   logic [3:0] maqs_in_mlsd;
   logic [2:0] maqs_in_mmsd;
   logic [3:0] maqs_in_slsd;
   logic [2:0] maqs_in_smsd;
   logic [3:0] maqs_mlsd;
   logic [2:0] maqs_mmsd;
   logic [3:0] maqs_slsd;
   logic [2:0] maqs_smsd;
   logic       maqs_running;
   logic       maqs_done;
   logic       maqs_alarm;

   modport master (
      output maqs_enable, maqs_load, maqs_start, maqs_stop,
      output maqs_in_mlsd, maqs_in_mmsd, maqs_in_slsd, maqs_in_smsd,
      input  maqs_mlsd, maqs_mmsd, maqs_slsd, maqs_smsd,
      input  maqs_running, maqs_done, maqs_alarm
   );

   modport slave (
      input  maqs_enable, maqs_load, maqs_start, maqs_stop,
      input  maqs_in_mlsd, maqs_in_mmsd, maqs_in_slsd, maqs_in_smsd,
      output maqs_mlsd, maqs_mmsd, maqs_slsd, maqs_smsd,
      output maqs_running, maqs_done, maqs_alarm
   );
endinterface

// File: rtl/maq_regressiva.sv
// MM:SS BCD countdown timer with pause, and an alarm that lasts ALARM_TICKS enable ticks.
module maq_regressiva #(
   parameter int ALARM_TICKS = 10
) (
   input  logic             maqs_clock,
   input  logic             maqs_reset,
   maq_regressiva_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

   localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

   state_t     state_q, state_d;
   logic [3:0] mlsd_q, mlsd_d;
   logic [2:0] mmsd_q, mmsd_d;
   logic [3:0] slsd_q, slsd_d;
   logic [2:0] smsd_q, smsd_d;
   logic [7:0] tick_cnt_q, tick_cnt_d;
   logic       done_q, done_d;

   logic [3:0] ld_mlsd, ld_slsd, dec_mlsd, dec_slsd;
   logic [2:0] ld_mmsd, ld_smsd, dec_mmsd, dec_smsd;
   logic       ld_nonzero, cur_nonzero, dec_zero;

   assign ld_mlsd = (bus.maqs_in_mlsd > 4'd9) ? 4'd9 : bus.maqs_in_mlsd;
   assign ld_slsd = (bus.maqs_in_slsd > 4'd9) ? 4'd9 : bus.maqs_in_slsd;
   assign ld_mmsd = (bus.maqs_in_mmsd > 3'd5) ? 3'd5 : bus.maqs_in_mmsd;
   assign ld_smsd = (bus.maqs_in_smsd > 3'd5) ? 3'd5 : bus.maqs_in_smsd;

   assign ld_nonzero  = |{ld_mmsd, ld_mlsd, ld_smsd, ld_slsd};
   assign cur_nonzero = |{mmsd_q, mlsd_q, smsd_q, slsd_q};

   // One-second decrement with the borrow rippling from seconds up to tens of minutes.
   always_comb begin
      dec_slsd = slsd_q - 4'd1;
      dec_smsd = smsd_q;
      dec_mlsd = mlsd_q;
      dec_mmsd = mmsd_q;
      if (slsd_q == 4'd0) begin
         dec_slsd = 4'd9;
         dec_smsd = smsd_q - 3'd1;
         if (smsd_q == 3'd0) begin
            dec_smsd = 3'd5;
            dec_mlsd = mlsd_q - 4'd1;
            if (mlsd_q == 4'd0) begin
               dec_mlsd = 4'd9;
               dec_mmsd = mmsd_q - 3'd1;
            end
         end
      end
   end

   assign dec_zero = ~|{dec_mmsd, dec_mlsd, dec_smsd, dec_slsd};

   always_comb begin
      state_d    = state_q;
      mlsd_d     = mlsd_q;
      mmsd_d     = mmsd_q;
      slsd_d     = slsd_q;
      smsd_d     = smsd_q;
      tick_cnt_d = tick_cnt_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE, PAUSE: begin
            // Start is judged against the freshly loaded value when both arrive together.
            if (bus.maqs_load) begin
               mlsd_d  = ld_mlsd;
               mmsd_d  = ld_mmsd;
               slsd_d  = ld_slsd;
               smsd_d  = ld_smsd;
               state_d = (bus.maqs_start && !bus.maqs_stop && ld_nonzero) ? RUN : IDLE;
            end else if (bus.maqs_stop) begin
               state_d = IDLE;
            end else if (bus.maqs_start && cur_nonzero) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.maqs_stop) begin
               state_d = PAUSE;
            end else if (bus.maqs_enable && cur_nonzero) begin
               mlsd_d = dec_mlsd;
               mmsd_d = dec_mmsd;
               slsd_d = dec_slsd;
               smsd_d = dec_smsd;
               if (dec_zero) begin
                  state_d    = ALARM;
                  done_d     = 1'b1;
                  tick_cnt_d = 8'd0;
               end
            end
         end
         ALARM: begin
            if (bus.maqs_load) begin
               mlsd_d  = ld_mlsd;
               mmsd_d  = ld_mmsd;
               slsd_d  = ld_slsd;
               smsd_d  = ld_smsd;
               state_d = IDLE;
            end else if (bus.maqs_stop) begin
               state_d = IDLE;
            end else if (bus.maqs_enable) begin
               if (tick_cnt_q == ALARM_LAST) begin
                  state_d    = IDLE;
                  tick_cnt_d = 8'd0;
               end else begin
                  tick_cnt_d = tick_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge maqs_clock or negedge maqs_reset) begin
      if (!maqs_reset) begin
         state_q    <= IDLE;
         mlsd_q     <= 4'd0;
         mmsd_q     <= 3'd0;
         slsd_q     <= 4'd0;
         smsd_q     <= 3'd0;
         tick_cnt_q <= 8'd0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mlsd_q     <= mlsd_d;
         mmsd_q     <= mmsd_d;
         slsd_q     <= slsd_d;
         smsd_q     <= smsd_d;
         tick_cnt_q <= tick_cnt_d;
         done_q     <= done_d;
      end
   end

   assign bus.maqs_mlsd    = mlsd_q;
   assign bus.maqs_mmsd    = mmsd_q;
   assign bus.maqs_slsd    = slsd_q;
   assign bus.maqs_smsd    = smsd_q;
   assign bus.maqs_running = (state_q == RUN);
   assign bus.maqs_alarm   = (state_q == ALARM);
   assign bus.maqs_done    = done_q;

endmodule

// File: tb/tb_maq_regressiva.sv
// Directed vector bench for maq_regressiva; times are BCD packed as 16'hMMSS, flags as {running, done, alarm}.
module tb_maq_regressiva;

   logic maqs_clock;
   logic maqs_reset;

   maq_regressiva_if bus ();

   maq_regressiva #(.ALARM_TICKS(3)) dut (
      .maqs_clock (maqs_clock),
      .maqs_reset (maqs_reset),
      .bus        (bus.slave)
   );

   initial maqs_clock = 1'b0;
   always #5 maqs_clock = ~maqs_clock;

   typedef struct {
      logic        ld;
      logic        st;
      logic        sp;
      logic        en;
      logic [15:0] in_t;
      logic [15:0] exp_t;
      logic [2:0]  exp_f;
   } vec_t;

   vec_t vecs [35];
   int   vectors;
   int   miscompares;

   function automatic logic [15:0] to_bcd(input int sec);
      int m;
      int s;
      m = sec / 60;
      s = sec % 60;
      return {1'b0, 3'(m / 10), 4'(m % 10), 1'b0, 3'(s / 10), 4'(s % 10)};
   endfunction

   task automatic applyStimulus(input logic ld, input logic st, input logic sp, input logic en,
                                input logic [15:0] t);
      bus.maqs_load    = ld;
      bus.maqs_start   = st;
      bus.maqs_stop    = sp;
      bus.maqs_enable  = en;
      bus.maqs_in_mmsd = t[14:12];
      bus.maqs_in_mlsd = t[11:8];
      bus.maqs_in_smsd = t[6:4];
      bus.maqs_in_slsd = t[3:0];
   endtask

   task automatic checkOutput(input string name, input int idx, input logic [15:0] exp_t,
                              input logic [2:0] exp_f);
      logic [15:0] act_t;
      logic [2:0]  act_f;
      act_t = {1'b0, bus.maqs_mmsd, bus.maqs_mlsd, 1'b0, bus.maqs_smsd, bus.maqs_slsd};
      act_f = {bus.maqs_running, bus.maqs_done, bus.maqs_alarm};
      vectors++;
      if (act_t !== exp_t || act_f !== exp_f) begin
         miscompares++;
         $display("[TB] FAIL %s[%0d]: got time %h flags %b, expected time %h flags %b",
                  name, idx, act_t, act_f, exp_t, exp_f);
      end
   endtask

   task automatic stepCheck(input string name, input int idx, input logic [15:0] exp_t,
                            input logic [2:0] exp_f);
      @(posedge maqs_clock);
      #1;
      checkOutput(name, idx, exp_t, exp_f);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      //            ld    st    sp    en    in        exp time  flags
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0100, 3'b000};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0100, 3'b100};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0059, 3'b100};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0059, 3'b100};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0058, 3'b100};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0500, 16'h0058, 3'b100};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0058, 3'b000};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0058, 3'b000};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0058, 3'b000};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h1000, 3'b000};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1000, 3'b100};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0959, 3'b100};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0959, 3'b000};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h7F7C, 16'h5959, 3'b000};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0002, 3'b100};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 3'b100};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'b011};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b001};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b001};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'b001};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'b001};
      vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'b000};
      vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000};
      vecs[23] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0005, 3'b100};
      vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0005, 3'b000};
      vecs[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0005, 3'b100};
      vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0004, 3'b100};
      vecs[27] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 3'b100};
      vecs[28] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 3'b100};
      vecs[29] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 3'b100};
      vecs[30] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'b011};
      vecs[31] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'b001};
      vecs[32] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'b000};
      vecs[33] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'b000};
      vecs[34] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000};

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      maqs_reset = 1'b1;
      #1 maqs_reset = 1'b0;
      #2;
      checkOutput("reset_async", 0, 16'h0000, 3'b000);
      @(posedge maqs_clock);
      #1;
      checkOutput("reset_held", 0, 16'h0000, 3'b000);
      maqs_reset = 1'b1;

      for (int i = 0; i < 35; i++) begin
         applyStimulus(vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].en, vecs[i].in_t);
         stepCheck("vec", i, vecs[i].exp_t, vecs[i].exp_f);
      end

      // Full minute countdown from 01:00 to the alarm, checked against a seconds model.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100);
      stepCheck("min_start", 0, 16'h0100, 3'b100);
      for (int k = 1; k <= 60; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
         stepCheck("min_tick", k, to_bcd(60 - k), (k == 60) ? 3'b011 : 3'b100);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      stepCheck("min_done_clear", 0, 16'h0000, 3'b001);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0300);
      stepCheck("alarm_load", 0, 16'h0300, 3'b000);

      // Reset in the middle of a countdown must clear everything without a clock edge.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
      stepCheck("rst_load", 0, 16'h1234, 3'b000);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      stepCheck("rst_start", 0, 16'h1234, 3'b100);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      #3 maqs_reset = 1'b0;
      #1;
      checkOutput("rst_mid_run", 0, 16'h0000, 3'b000);
      #2 maqs_reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      stepCheck("rst_after_tick", 0, 16'h0000, 3'b000);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
      stepCheck("rst_after_start", 0, 16'h0000, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
